interboard_rx: RTL and testbench

Receiving end of the inter-board move protocol. The peer board's control logic emits one move message as a 22-bit packet (msg type, block x/y, card, selection length, move direction). This block deserialises it from a 4-bit bus using a four-phase req/ack handshake and presents it to the local game controller as `interboard_en` plus decoded fields. It sits between the board-to-board pins and GameControl.

---
 rtl/interboard_pkg.sv | 53 +++++
 rtl/interboard_if.sv | 29 ++
 rtl/sync_ff.sv | 20 ++
 rtl/interboard_rx.sv | 118 +++++++++++
 tb/tb_interboard_rx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board move protocol (receiver and future transmitter).
package interboard_pkg;

  localparam int unsigned NIBBLES = 6;
  localparam int unsigned PKT_W   = 4 * NIBBLES;

  typedef enum logic [3:0] {
    TABLE_TAKE      = 4'd0,
    TABLE_DOWN      = 4'd1,
    TABLE_SHIFT     = 4'd2,
    HAND_TAKE       = 4'd3,
    HAND_DOWN       = 4'd4,
    DECK_DRAW       = 4'd5,
    STATE_TURN      = 4'd6,
    STATE_RST_TABLE = 4'd7,
    STATE_CHEAT     = 4'd8
  } msg_type_e;

  localparam logic [3:0] MSG_MAX = 4'(STATE_CHEAT);

  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned X_LSB    = 4;
  localparam int unsigned Y_LSB    = 9;
  localparam int unsigned CARD_LSB = 12;
  localparam int unsigned SEL_LSB  = 18;
  localparam int unsigned DIR_LSB  = 21;

  typedef struct packed {
    logic [3:0] msg_type;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [5:0] card;
    logic [2:0] sel_len;
    logic       move_dir;
  } move_msg_t;

  // Bits [23:22] are reserved and deliberately not extracted.
  function automatic move_msg_t unpack_msg(input logic [PKT_W-1:0] pkt);
    move_msg_t m;
    m.msg_type = pkt[TYPE_LSB +: 4];
    m.block_x  = pkt[X_LSB    +: 5];
    m.block_y  = pkt[Y_LSB    +: 3];
    m.card     = pkt[CARD_LSB +: 6];
    m.sel_len  = pkt[SEL_LSB  +: 3];
    m.move_dir = pkt[DIR_LSB];
    return m;
  endfunction

  function automatic logic msg_valid(input logic [3:0] msg_type);
    return msg_type <= MSG_MAX;
  endfunction

endpackage

// File: rtl/interboard_if.sv
// Board-to-board receive pins plus the decoded message towards GameControl.
interface interboard_if;
  logic       rx_req;
  logic [3:0] rx_data;
  logic       rx_ack;
  logic       interboard_en;
  logic [3:0] interboard_msg_type;
  logic [4:0] interboard_block_x;
  logic [2:0] interboard_block_y;
  logic [5:0] interboard_card;
  logic [2:0] interboard_sel_len;
  logic       interboard_move_dir;
  logic       rx_error;
  logic       rx_busy;

  modport master (
    output rx_req, rx_data,
    input  rx_ack, interboard_en, interboard_msg_type, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len,
           interboard_move_dir, rx_error, rx_busy
  );

  modport slave (
    input  rx_req, rx_data,
    output rx_ack, interboard_en, interboard_msg_type, interboard_block_x,
           interboard_block_y, interboard_card, interboard_sel_len,
           interboard_move_dir, rx_error, rx_busy
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stg <= '0;
    else     stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/interboard_rx.sv
// Four-phase req/ack nibble deserialiser for inter-board move messages,
// with a progress watchdog that aborts stalled packets.
module interboard_rx
  import interboard_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  interboard_if.slave bus
);

  localparam int unsigned WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [2:0]      LAST_NIB = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {WAIT_REQ, ACK, FLUSH} state_e;

  state_e           state;
  logic [2:0]       cnt;
  logic [PKT_W-1:0] pkt;
  logic [WD_W-1:0]  wdog;
  logic             req_s;
  logic             ack, en, err, busy;
  move_msg_t        fields;
  move_msg_t        rx_msg;
  logic             counting;

  sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_req),
    .q   (req_s)
  );

  assign rx_msg = unpack_msg(pkt);

  // Watchdog only runs while a handshake is owed by the peer mid-packet.
  always_comb begin
    counting = 1'b0;
    if (state == ACK && req_s)                        counting = 1'b1;
    if (state == WAIT_REQ && !req_s && cnt != 3'd0)   counting = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT_REQ;
      cnt    <= '0;
      pkt    <= '0;
      wdog   <= '0;
      ack    <= 1'b0;
      en     <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      fields <= '0;
    end else begin
      en  <= 1'b0;
      err <= 1'b0;
      if (counting && wdog == WD_LAST) begin
        err   <= 1'b1;
        ack   <= 1'b0;
        cnt   <= '0;
        pkt   <= '0;
        wdog  <= '0;
        busy  <= 1'b1;
        state <= FLUSH;
      end else begin
        if (counting) wdog <= wdog + 1'b1;
        unique case (state)
          WAIT_REQ: if (req_s) begin
            pkt[4*cnt +: 4] <= bus.rx_data;
            ack   <= 1'b1;
            busy  <= 1'b1;
            wdog  <= '0;
            state <= ACK;
          end
          ACK: if (!req_s) begin
            ack   <= 1'b0;
            wdog  <= '0;
            state <= WAIT_REQ;
            if (cnt == LAST_NIB) begin
              cnt  <= '0;
              busy <= 1'b0;
              if (msg_valid(rx_msg.msg_type)) begin
                fields <= rx_msg;
                en     <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          FLUSH: if (!req_s) begin
            cnt   <= '0;
            wdog  <= '0;
            busy  <= 1'b0;
            state <= WAIT_REQ;
          end
          default: state <= WAIT_REQ;
        endcase
      end
    end
  end

  assign bus.rx_ack              = ack;
  assign bus.interboard_en       = en;
  assign bus.interboard_msg_type = fields.msg_type;
  assign bus.interboard_block_x  = fields.block_x;
  assign bus.interboard_block_y  = fields.block_y;
  assign bus.interboard_card     = fields.card;
  assign bus.interboard_sel_len  = fields.sel_len;
  assign bus.interboard_move_dir = fields.move_dir;
  assign bus.rx_error            = err;
  assign bus.rx_busy             = busy;

endmodule

// File: tb/tb_interboard_rx.sv
// Self-checking bench for interboard_rx: directed table, random packets against
// an arithmetic decode model, and hand-written timeout/reset/back-to-back sequences.
module tb_interboard_rx;

  localparam int unsigned TO = 64;
  localparam int unsigned SS = 2;

  typedef struct packed {
    logic [3:0] t;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c;
    logic [2:0] s;
    logic       d;
  } fld_t;

  typedef struct {
    logic [23:0] pkt;
    logic        en;
    fld_t        f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interboard_if bus();

  interboard_rx #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned en_cnt = 0;
  int unsigned err_cnt = 0;
  fld_t        got_q[$];
  fld_t        hold;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic fld_t cur_fields();
    return {bus.interboard_msg_type, bus.interboard_block_x, bus.interboard_block_y,
            bus.interboard_card, bus.interboard_sel_len, bus.interboard_move_dir};
  endfunction

  function automatic int unsigned all_outputs();
    return int'({bus.rx_ack, bus.interboard_en, cur_fields(), bus.rx_error, bus.rx_busy});
  endfunction

  // Reference decode: plain arithmetic on the 24-bit packet value.
  function automatic fld_t model(input logic [23:0] p);
    int unsigned v;
    fld_t f;
    v   = int'(p);
    f.t = 4'(v % 16);
    f.x = 5'((v / 16) % 32);
    f.y = 3'((v / 512) % 8);
    f.c = 6'((v / 4096) % 64);
    f.s = 3'((v / 262144) % 8);
    f.d = 1'((v / 2097152) % 2);
    return f;
  endfunction

  always @(negedge clk) begin
    if (bus.interboard_en) begin
      en_cnt++;
      got_q.push_back(cur_fields());
    end
    if (bus.rx_error) err_cnt++;
    if (bus.interboard_en || bus.rx_error)
      check("en_err_exclusive", int'(bus.interboard_en & bus.rx_error), 0);
  end

  task automatic wait_ack(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rx_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_nib(input logic [3:0] d);
    bit ok;
    bus.rx_data = d;
    bus.rx_req  = 1'b1;
    wait_ack(1'b1, ok);
    if (!ok) check("ack_rise_bound", int'(ok), 1);
    bus.rx_req  = 1'b0;
    bus.rx_data = 4'($urandom);
    wait_ack(1'b0, ok);
    if (!ok) check("ack_fall_bound", int'(ok), 1);
  endtask

  task automatic send_pkt(input logic [23:0] p, input int unsigned first, input int unsigned last);
    for (int unsigned k = first; k <= last; k++) send_nib(p[4*k +: 4]);
  endtask

  task automatic apply_vec(input string name, input logic [23:0] p, input logic exp_en, input fld_t exp_f);
    int unsigned e0, r0;
    e0 = en_cnt;
    r0 = err_cnt;
    send_pkt(p, 0, 5);
    repeat (3) @(negedge clk);
    check({name, "_en"}, en_cnt - e0, int'(exp_en));
    check({name, "_err"}, err_cnt - r0, int'(!exp_en));
    check({name, "_fields"}, int'(cur_fields()), int'(exp_f));
    check({name, "_busy"}, int'(bus.rx_busy), 0);
  endtask

  task automatic apply_model(input string name, input logic [23:0] p);
    logic v;
    v = (int'(p) % 16) <= 8;
    if (v) hold = model(p);
    apply_vec(name, p, v, hold);
  endtask

  function automatic logic [23:0] rand_valid();
    logic [23:0] p;
    p      = 24'($urandom);
    p[3:0] = 4'($urandom_range(0, 8));
    return p;
  endfunction

  initial begin
    #3ms;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[7];
    logic [23:0] p, p2;
    int unsigned n, r0, e0;
    bit          ok;

    tbl[0] = '{24'h2EAB11, 1'b1, fld_t'{4'd1, 5'd17, 3'd5, 6'd42, 3'd3, 1'b1}};
    tbl[1] = '{24'h00000C, 1'b0, fld_t'{4'd1, 5'd17, 3'd5, 6'd42, 3'd3, 1'b1}};
    tbl[2] = '{24'hFFFFF8, 1'b1, fld_t'{4'd8, 5'd31, 3'd7, 6'd63, 3'd7, 1'b1}};
    tbl[3] = '{24'h000009, 1'b0, fld_t'{4'd8, 5'd31, 3'd7, 6'd63, 3'd7, 1'b1}};
    tbl[4] = '{24'h000000, 1'b1, fld_t'{4'd0, 5'd0,  3'd0, 6'd0,  3'd0, 1'b0}};
    tbl[5] = '{24'hD0A435, 1'b1, fld_t'{4'd5, 5'd3,  3'd2, 6'd10, 3'd4, 1'b0}};
    tbl[6] = '{24'h3FFFFF, 1'b0, fld_t'{4'd5, 5'd3,  3'd2, 6'd10, 3'd4, 1'b0}};

    bus.rx_req  = 1'b0;
    bus.rx_data = 4'h0;
    hold        = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", all_outputs(), 0);

    for (int i = 0; i < 7; i++) begin
      apply_vec($sformatf("tbl%0d", i), tbl[i].pkt, tbl[i].en, tbl[i].f);
      hold = tbl[i].f;
    end

    for (int i = 0; i < 16; i++) begin
      p = (i % 2 == 0) ? rand_valid() : 24'($urandom);
      apply_model($sformatf("rand%0d", i), p);
    end

    // Stall after four nibbles with rx_req low.
    r0 = err_cnt;
    send_pkt(rand_valid(), 0, 3);
    check("stall_busy", int'(bus.rx_busy), 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (bus.rx_error) break;
    end
    check("stall_timeout_cycles", n, TO);
    repeat (2) @(negedge clk);
    check("stall_busy_after", int'(bus.rx_busy), 0);
    check("stall_err_count", err_cnt - r0, 1);
    check("stall_fields_held", int'(cur_fields()), int'(hold));
    apply_model("after_stall", rand_valid());

    // Peer holds rx_req high forever.
    r0 = err_cnt;
    e0 = en_cnt;
    bus.rx_data = 4'($urandom_range(0, 8));
    bus.rx_req  = 1'b1;
    wait_ack(1'b1, ok);
    check("stuck_ack_rise", int'(ok), 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (bus.rx_error) break;
    end
    check("stuck_timeout_cycles", n, TO);
    check("stuck_ack_dropped", int'(bus.rx_ack), 0);
    repeat (20) @(negedge clk);
    check("stuck_flush_ack_busy", int'({bus.rx_ack, bus.rx_busy}), 1);
    bus.rx_req = 1'b0;
    repeat (5) @(negedge clk);
    check("stuck_release_busy", int'(bus.rx_busy), 0);
    check("stuck_err_en", int'({8'(err_cnt - r0), 8'(en_cnt - e0)}), 32'h100);
    apply_model("after_stuck", rand_valid());

    // Reset while the third nibble is being acknowledged; peer keeps rx_req high across it.
    p  = rand_valid();
    p2 = rand_valid();
    send_pkt(p, 0, 1);
    bus.rx_data = p2[3:0];
    bus.rx_req  = 1'b1;
    wait_ack(1'b1, ok);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", all_outputs(), 0);
    hold = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = en_cnt;
    r0 = err_cnt;
    wait_ack(1'b1, ok);
    check("post_reset_ack", int'(ok), 1);
    bus.rx_req = 1'b0;
    wait_ack(1'b0, ok);
    send_pkt(p2, 1, 5);
    repeat (3) @(negedge clk);
    check("post_reset_en_err", int'({8'(en_cnt - e0), 8'(err_cnt - r0)}), 32'h100);
    hold = model(p2);
    check("post_reset_fields", int'(cur_fields()), int'(hold));

    // Two packets with no idle gap between them.
    p  = rand_valid();
    p2 = p ^ 24'h155550;
    r0 = err_cnt;
    got_q.delete();
    send_pkt(p, 0, 5);
    send_pkt(p2, 0, 5);
    repeat (3) @(negedge clk);
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first", int'(got_q[0]), int'(model(p)));
      check("b2b_second", int'(got_q[1]), int'(model(p2)));
    end
    check("b2b_err", err_cnt - r0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
